// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF and DM, DM priority with starvation guard for IF
module mem_port_arbiter #(
  parameter int STARVE_MAX = 3,
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ready,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, DONE} state_t;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(STARVE_MAX);
  state_t state, state_nx;
  logic [CNT_W-1:0] starve_cnt;
  logic force_if, grant_dm, grant_if, ack_if, ack_dm;
  assign force_if = (starve_cnt == MAX_CNT) & if_req;
  assign grant_dm = (state == IDLE) & dm_req & ~force_if;
  assign grant_if = (state == IDLE) & ~grant_dm & if_req;
  assign ack_if = (state == BUSY_IF) & mem_ack;
  assign ack_dm = (state == BUSY_DM) & mem_ack;
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (grant_dm ? BUSY_DM : grant_if ? BUSY_IF : IDLE) :
               (state == DONE) ? IDLE :
               mem_ack ? DONE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      starve_cnt <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      state <= state_nx;
      mem_en <= grant_dm | grant_if;
      if (grant_dm) begin
        mem_addr <= dm_addr;
        mem_we <= dm_we;
        mem_wdata <= dm_wdata;
        starve_cnt <= !if_req ? '0 : (starve_cnt == MAX_CNT) ? starve_cnt : starve_cnt + 1'b1;
      end else if (grant_if) begin
        mem_addr <= if_addr;
        mem_we <= 1'b0;
        starve_cnt <= '0;
      end
      if_ready <= ack_if;
      dm_ready <= ack_dm;
      if (ack_if) if_rdata <= mem_rdata;
      if (ack_dm & ~mem_we) dm_rdata <= mem_rdata;
    end
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch-stage instruction port (IF) and the memory-stage data port (DM).
- Sits between the pipeline and the memory. It replaces the separate instruction memory and data memory with one port.
- Stalls are derived from its ready pulses.
- Priority is DM over IF, with a starvation guard so fetch always makes progress.

Parameters:
STARVE_MAX, 3, max consecutive DM grants while IF is pending before IF is forced a grant (>=1)
CNT_W, 2, width of starvation counter (must hold STARVE_MAX)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
if_req  input  1  IF read request, held until if_ready
if_addr  input  32  IF byte address, held stable while if_req
if_ready  output  1  one-cycle pulse: IF access done, if_rdata valid
if_rdata  output  32  registered IF read data
dm_req  input  1  DM request, held until dm_ready
dm_we  input  1  DM write enable (1=write, 0=read)
dm_addr  input  32  DM byte address
dm_wdata  input  32  DM write data
dm_ready  output  1  one-cycle pulse: DM access done
dm_rdata  output  32  registered DM read data (reads only)
mem_en  output  1  one-cycle command strobe to memory
mem_we  output  1  write qualifier, valid with mem_en
mem_addr  output  32  latched address, stable from mem_en until ack
mem_wdata  output  32  latched write data
mem_ack  input  1  memory completion, one cycle; read data valid on mem_rdata same cycle
mem_rdata  input  32  memory read data

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset (rst_n=0 at a rising edge) applies at any point, including mid-transaction:
  - state=IDLE, starve_cnt=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - if_ready=0, dm_ready=0, if_rdata=0, dm_rdata=0.
  - An outstanding access is abandoned; a later mem_ack is ignored.
- All outputs are registered.
- States: IDLE, BUSY_IF, BUSY_DM, DONE.
- IDLE arbitration, at each edge:
  - force_if = (starve_cnt==STARVE_MAX) & if_req.
  - dm_req & ~force_if -> BUSY_DM.
    - Latch dm_addr/dm_we/dm_wdata onto mem_*; mem_en=1.
    - starve_cnt = if_req ? starve_cnt+1 : 0.
  - else if_req -> BUSY_IF.
    - Latch if_addr; mem_we=0, mem_wdata unchanged; mem_en=1; starve_cnt=0.
  - else stay IDLE.
- BUSY_x:
  - mem_en is high only in the first BUSY cycle, then 0.
  - mem_addr/mem_we/mem_wdata are held.
  - mem_ack is sampled every BUSY cycle, including the first (zero-wait memory allowed).
  - On mem_ack:
    - Go to DONE.
    - Pulse the matching ready for exactly one cycle.
    - For a read, capture mem_rdata into if_rdata/dm_rdata.
    - A DM write leaves dm_rdata unchanged.
- DONE: one cycle with no grant, so a requester can drop or replace its request after seeing ready. DONE -> IDLE unconditionally.
- Latency: request seen in IDLE at edge t gives mem_en in cycle t+1. Ack at cycle k gives ready in cycle k+1. Minimum 3 cycles from grant to the next possible grant.
- mem_ack in IDLE or DONE: ignored; no ready, no data capture.
- Request dropped mid-access: the access still completes and ready still pulses; the requester ignores it.
- Input changes during BUSY have no effect; command fields are latched.
- if_ready and dm_ready are never high in the same cycle.
- At most one outstanding memory command.
- starve_cnt saturates at STARVE_MAX; it never wraps.
- Stall contract for the pipeline: StallF = if_req & ~if_ready; stall for memory stage = dm_req & ~dm_ready.

Test Plan:
1. Reset mid-access:
   - Stimulus: IF grant to 0x0000_0040, rst_n=0 for 1 cycle before ack, then mem_ack=1 after release.
   - Required: all outputs 0, no if_ready pulse, state IDLE, next if_req reissues mem_en.
2. Single IF read, zero-wait:
   - Stimulus: if_req, if_addr=0x0040_0000, mem_ack in same cycle as mem_en, mem_rdata=0x2008_0005.
   - Required: mem_en 1 cycle with mem_addr=0x0040_0000, mem_we=0; if_ready one cycle later with if_rdata=0x2008_0005; then DONE, then IDLE.
3. DM write with 3-cycle wait:
   - Stimulus: dm_we=1, dm_addr=0x1001_0000, dm_wdata=0xDEAD_BEEF; dm_addr changes to 0x1234 during BUSY.
   - Required: mem_en/mem_we pulse with mem_wdata=0xDEAD_BEEF; mem_addr stays 0x1001_0000 until ack; dm_ready 1 cycle after ack; dm_rdata unchanged.
4. Simultaneous requests:
   - Stimulus: if_req and dm_req rise together, DM read returns 0x0000_00AA.
   - Required: DM served first; IF granted right after DONE; ready pulses never overlap.
5. Starvation guard, STARVE_MAX=3:
   - Stimulus: if_req held; dm_req held with a new access each time.
   - Required: grant order DM, DM, DM, IF, DM…; starve_cnt 1,2,3 then 0.
6. Stray and dropped:
   - Stimulus: mem_ack while IDLE; separately, dm_req dropped mid-BUSY.
   - Required: stray ack gives no ready and no rdata change; the dropped access still completes with a dm_ready pulse, then IDLE.
